// File: rtl/perspective_divide_if.sv
// rtl/perspective_divide_if.sv - vertex-in / result-out handshake bundle for perspective_divide
interface perspective_divide_if #(
  parameter int WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0][WIDTH-1:0] in_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0][WIDTH-1:0] out_vec;
  logic                  out_dz;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec, out_dz
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec, out_dz
  );
endinterface

// File: rtl/perspective_divide.sv
// rtl/perspective_divide.sv - x/w, y/w, z/w in signed fixed point via one shared restoring divider
module perspective_divide #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input logic                 clk,
  input logic                 rst,
  perspective_divide_if.slave bus
);
  localparam int MW = WIDTH + 1;
  localparam int QW = MW + FRAC;
  localparam int KW = $clog2(QW + 1);
  localparam logic [KW-1:0]    K_LAST = KW'(QW);
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            c_q, c_d;
  logic [KW-1:0]         k_q, k_d;
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic [QW-1:0]         quo_q, quo_d;
  logic [3:0][WIDTH-1:0] vec_q, vec_d;
  logic [2:0][WIDTH-1:0] out_vec_q, out_vec_d;
  logic                  out_dz_q, out_dz_d;

  logic [MW-1:0]         trial;
  logic [MW-1:0]         divisor;

  // One extra magnitude bit so that the most negative input maps to a positive value.
  function automatic logic [MW-1:0] mag(input logic [WIDTH-1:0] v);
    logic [MW-1:0] s;
    s = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -s : s;
  endfunction

  function automatic logic [WIDTH-1:0] sat_zero(input logic [WIDTH-1:0] v);
    if (v == '0)
      return '0;
    else if (v[WIDTH-1])
      return NEG_MAX;
    else
      return POS_MAX;
  endfunction

  function automatic logic [WIDTH-1:0] finalize(input logic [QW-1:0] q, input logic neg);
    logic [WIDTH-1:0] lo;
    lo = q[WIDTH-1:0];
    if (!neg)
      return (q > QW'(POS_MAX)) ? POS_MAX : lo;
    else
      return (q > QW'(NEG_MAX)) ? NEG_MAX : -lo;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      c_q       <= '0;
      k_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      vec_q     <= '0;
      out_vec_q <= '0;
      out_dz_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      k_q       <= k_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      vec_q     <= vec_d;
      out_vec_q <= out_vec_d;
      out_dz_q  <= out_dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    k_d       = k_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    vec_d     = vec_q;
    out_vec_d = out_vec_q;
    out_dz_d  = out_dz_q;
    trial     = {rem_q, quo_q[QW-1]};
    divisor   = mag(vec_q[3]);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          vec_d = bus.in_vec;
          if (bus.in_vec[3] == '0) begin
            for (int i = 0; i < 3; i++)
              out_vec_d[i] = sat_zero(bus.in_vec[i]);
            out_dz_d = 1'b1;
            state_d  = DONE;
          end else begin
            out_dz_d = 1'b0;
            c_d      = '0;
            k_d      = '0;
            rem_d    = '0;
            quo_d    = {mag(bus.in_vec[0]), {FRAC{1'b0}}};
            state_d  = DIV;
          end
        end
      end
      DIV: begin
        if (k_q != K_LAST) begin
          // quo_q shifts the dividend out of its top while quotient bits enter at the bottom.
          if (trial >= divisor) begin
            rem_d = WIDTH'(trial - divisor);
            quo_d = {quo_q[QW-2:0], 1'b1};
          end else begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[QW-2:0], 1'b0};
          end
          k_d = k_q + 1'b1;
        end else begin
          out_vec_d[c_q] = finalize(quo_q, vec_q[c_q][WIDTH-1] ^ vec_q[3][WIDTH-1]);
          k_d   = '0;
          rem_d = '0;
          quo_d = {mag(vec_q[c_q + 2'd1]), {FRAC{1'b0}}};
          if (c_q == 2'd2)
            state_d = DONE;
          else
            c_d = c_q + 2'd1;
        end
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_vec   = out_vec_q;
    bus.out_dz    = out_dz_q;
  end
endmodule

// File: tb/tb_perspective_divide.sv
// tb/tb_perspective_divide.sv - directed-vector bench for perspective_divide
module tb_perspective_divide;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  perspective_divide_if #(.WIDTH(16)) bus ();

  perspective_divide #(.WIDTH(16), .FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one vertex for exactly one rising edge; call just after an edge.
  task automatic send(input logic [15:0] x, y, z, w);
    bus.in_valid = 1'b1;
    bus.in_vec   = {w, z, y, x};
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges after the acceptance edge until out_valid is seen; 999 if it never comes.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.out_valid) n = 999;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_vec !== 48'h0) begin n_fail++; $display("FAIL reset_out_vec got %h want 0", bus.out_vec); end
    n_checks++; if (bus.out_dz !== 1'b0) begin n_fail++; $display("FAIL reset_out_dz got %b want 0", bus.out_dz); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int n;
    logic [47:0] exp;
    exp = {16'h0040, 16'hFF80, 16'h0100};
    send(16'h0200, 16'hFF00, 16'h0080, 16'h0200);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy in_ready got %b want 0", bus.in_ready); end
    wait_valid(n);
    n_checks++; if (n !== 78) begin n_fail++; $display("FAIL basic_latency got %0d want 78", n); end
    n_checks++; if (bus.out_vec !== exp) begin n_fail++; $display("FAIL basic_vec got %h want %h", bus.out_vec, exp); end
    n_checks++; if (bus.out_dz !== 1'b0) begin n_fail++; $display("FAIL basic_dz got %b want 0", bus.out_dz); end
    consume();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back got %b want 1", bus.in_ready); end
  endtask

  task automatic test_zero_w();
    int n;
    logic [47:0] exp;
    exp = {16'h0000, 16'h8000, 16'h7FFF};
    send(16'h0100, 16'hFF00, 16'h0000, 16'h0000);
    wait_valid(n);
    n_checks++; if (n !== 0) begin n_fail++; $display("FAIL dz_latency got %0d want 0", n); end
    n_checks++; if (bus.out_vec !== exp) begin n_fail++; $display("FAIL dz_vec got %h want %h", bus.out_vec, exp); end
    n_checks++; if (bus.out_dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", bus.out_dz); end
    consume();
  endtask

  task automatic test_saturation();
    logic [15:0] xs [3];
    logic [15:0] ws [3];
    logic [15:0] ex [3];
    int n;
    xs = '{16'h7FFF, 16'h0300, 16'h8000};
    ws = '{16'h0001, 16'hFF00, 16'h8000};
    ex = '{16'h7FFF, 16'hFD00, 16'h0100};
    for (int i = 0; i < 3; i++) begin
      send(xs[i], 16'h0000, 16'h0000, ws[i]);
      wait_valid(n);
      n_checks++; if (bus.out_vec[0] !== ex[i]) begin n_fail++; $display("FAIL sat_%0d x/w got %h want %h", i, bus.out_vec[0], ex[i]); end
      n_checks++; if (bus.out_vec[2:1] !== 32'h0) begin n_fail++; $display("FAIL sat_%0d zero_num got %h want 0", i, bus.out_vec[2:1]); end
      consume();
    end
  endtask

  task automatic test_truncation();
    int n;
    logic [47:0] exp;
    exp = {16'h00AA, 16'hFFAB, 16'h0055};
    send(16'h0100, 16'hFF00, 16'h0200, 16'h0300);
    wait_valid(n);
    n_checks++; if (bus.out_vec !== exp) begin n_fail++; $display("FAIL trunc_vec got %h want %h", bus.out_vec, exp); end
    consume();
  endtask

  task automatic test_backpressure();
    int n;
    logic [47:0] exp1;
    logic [47:0] exp2;
    exp1 = {16'h0000, 16'h0000, 16'h0100};
    exp2 = {16'h00AA, 16'hFFAB, 16'h0055};
    send(16'h0200, 16'h0000, 16'h0000, 16'h0200);
    wait_valid(n);
    bus.in_valid = 1'b1;
    bus.in_vec   = {16'h0300, 16'h0200, 16'hFF00, 16'h0100};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (bus.out_vec !== exp1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_%0d vec %h valid %b want %h 1", i, bus.out_vec, bus.out_valid, exp1); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got %b want 0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept in_ready got %b want 0", bus.in_ready); end
    wait_valid(n);
    n_checks++; if (n !== 78) begin n_fail++; $display("FAIL bp_latency got %0d want 78", n); end
    n_checks++; if (bus.out_vec !== exp2) begin n_fail++; $display("FAIL bp_second_vec got %h want %h", bus.out_vec, exp2); end
    consume();
  endtask

  task automatic test_reset_mid_div();
    int n;
    send(16'h0300, 16'h0100, 16'h0000, 16'h0100);
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_vec !== 48'h0) begin n_fail++; $display("FAIL rstmid_vec got %h want 0", bus.out_vec); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.in_vec   = {16'h0200, 16'h0000, 16'h0000, 16'h0200};
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_held ready %b valid %b want 1 0", bus.in_ready, bus.out_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(n);
    n_checks++; if (n !== 78) begin n_fail++; $display("FAIL rstmid_latency got %0d want 78", n); end
    n_checks++; if (bus.out_vec !== {16'h0000, 16'h0000, 16'h0100}) begin n_fail++; $display("FAIL rstmid_vec2 got %h want 000000000100", bus.out_vec); end
    consume();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_zero_w();
    test_saturation();
    test_truncation();
    test_backpressure();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
